// File: rtl/wb_mem_arbiter.sv
//------------------------------------------------------------------------------
// wb_mem_arbiter
//   Two-master / one-slave Wishbone arbiter sharing main memory between the
//   instruction-fetch port (M0) and the load/store port (M1). Round-robin
//   grant on ties, the owner holds the bus for as long as its cyc stays high,
//   and an ack watchdog aborts a hung transfer with a one-cycle error pulse.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-high reset
//   i_mX_cyc/stb/we         master X Wishbone control (X = 0, 1)
//   i_mX_addr/data/sel      master X address, write data, byte selects
//   o_mX_ack/err/stall      master X ack, watchdog error pulse, stall
//   o_mX_data               read data to master X (slave data, broadcast)
//   o_s_cyc/stb/we          slave Wishbone control
//   o_s_addr/data/sel       slave address, write data, byte selects
//   i_s_ack/stall/data      slave ack, stall, read data
//   o_grant                 one-hot owner (bit0 = M0, bit1 = M1), 00 when idle
//   o_busy                  high whenever the arbiter is not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [31:0]           i_m0_data,
  input  logic [3:0]            i_m0_sel,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic                  o_m0_stall,
  output logic [31:0]           o_m0_data,
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [31:0]           i_m1_data,
  input  logic [3:0]            i_m1_sel,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic                  o_m1_stall,
  output logic [31:0]           o_m1_data,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [31:0]           o_s_data,
  output logic [3:0]            o_s_sel,
  input  logic                  i_s_ack,
  input  logic                  i_s_stall,
  input  logic [31:0]           i_s_data,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

  state_t                state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  last_owner, last_owner_nxt;
  logic [7:0]            wd_cnt, wd_cnt_nxt;
  logic                  err_pulse, err_pulse_nxt;

  logic                  req0, req1;
  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [31:0]           own_data;
  logic [3:0]            own_sel;

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  // Owner's request, selected from the registered owner bit.
  assign own_cyc  = owner ? i_m1_cyc  : i_m0_cyc;
  assign own_stb  = owner ? i_m1_stb  : i_m0_stb;
  assign own_we   = owner ? i_m1_we   : i_m0_we;
  assign own_addr = owner ? i_m1_addr : i_m0_addr;
  assign own_data = owner ? i_m1_data : i_m0_data;
  assign own_sel  = owner ? i_m1_sel  : i_m0_sel;

  // Control state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wd_cnt     <= 8'd0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      wd_cnt     <= wd_cnt_nxt;
      err_pulse  <= err_pulse_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    wd_cnt_nxt     = wd_cnt;
    err_pulse_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          // Tie goes to whoever did not own the bus last.
          owner_nxt  = (req0 & req1) ? ~last_owner : req1;
          state_nxt  = BUSY;
          wd_cnt_nxt = 8'd0;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          wd_cnt_nxt     = 8'd0;
        end else if (wd_cnt == WD_MAX && !i_s_ack) begin
          state_nxt     = ERR;
          err_pulse_nxt = 1'b1;
        end else if (own_stb && !i_s_ack) begin
          wd_cnt_nxt = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 8'd1;
        end else begin
          wd_cnt_nxt = 8'd0;
        end
      end
      ERR: begin
        if (!own_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          wd_cnt_nxt     = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus routing; slave ack is only forwarded while BUSY.
  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_sel    = '0;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    o_m0_stall = i_m0_cyc;
    o_m1_stall = i_m1_cyc;
    o_grant    = 2'b00;
    case (state)
      BUSY: begin
        o_s_cyc  = own_cyc;
        o_s_stb  = own_stb;
        o_s_we   = own_we;
        o_s_addr = own_addr;
        o_s_data = own_data;
        o_s_sel  = own_sel;
        o_grant  = owner ? 2'b10 : 2'b01;
        if (owner) begin
          o_m1_ack   = i_s_ack;
          o_m1_stall = i_s_stall;
        end else begin
          o_m0_ack   = i_s_ack;
          o_m0_stall = i_s_stall;
        end
      end
      ERR: begin
        o_grant = owner ? 2'b10 : 2'b01;
        if (owner) begin
          o_m1_stall = 1'b1;
        end else begin
          o_m0_stall = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_m0_err  = err_pulse & ~owner;
  assign o_m1_err  = err_pulse & owner;
  assign o_m0_data = i_s_data;
  assign o_m1_data = i_s_data;
  assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [31:0]   i_m0_data;
  logic [3:0]    i_m0_sel;
  logic          o_m0_ack, o_m0_err, o_m0_stall;
  logic [31:0]   o_m0_data;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [31:0]   i_m1_data;
  logic [3:0]    i_m1_sel;
  logic          o_m1_ack, o_m1_err, o_m1_stall;
  logic [31:0]   o_m1_data;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0] o_s_addr;
  logic [31:0]   o_s_data;
  logic [3:0]    o_s_sel;
  logic          i_s_ack, i_s_stall;
  logic [31:0]   i_s_data;
  logic [1:0]    o_grant;
  logic          o_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    sel;
  } req_t;

  typedef struct {
    logic        m;
    logic [31:0] data;
  } rsp_t;

  req_t req_q0[$];
  req_t req_q1[$];
  rsp_t rsp_q[$];

  wb_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_stall(o_m0_stall), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_stall(o_m1_stall), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_data(i_s_data),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic nxt();
    @(negedge i_clk);
  endtask

  task automatic m0(input logic c, input logic s, input logic w,
                    input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    i_m0_cyc = c; i_m0_stb = s; i_m0_we = w; i_m0_addr = a; i_m0_data = d; i_m0_sel = sl;
  endtask

  task automatic m1(input logic c, input logic s, input logic w,
                    input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] sl);
    i_m1_cyc = c; i_m1_stb = s; i_m1_we = w; i_m1_addr = a; i_m1_data = d; i_m1_sel = sl;
  endtask

  task automatic slv(input logic ack, input logic stall, input logic [31:0] d);
    i_s_ack = ack; i_s_stall = stall; i_s_data = d;
  endtask

  task automatic idle_all();
    m0(0, 0, 0, '0, '0, '0);
    m1(0, 0, 0, '0, '0, '0);
    slv(0, 0, '0);
  endtask

  task automatic push_req(input logic m, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] sl);
    req_t e;
    e.we = w; e.addr = a; e.data = d; e.sel = sl;
    if (m) req_q1.push_back(e);
    else   req_q0.push_back(e);
  endtask

  task automatic push_rsp(input logic m, input logic [31:0] d);
    rsp_t r;
    r.m = m; r.data = d;
    rsp_q.push_back(r);
  endtask

  task automatic apply_reset();
    nxt();
    idle_all();
    i_rst = 1'b1;
    nxt();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle_all();
    i_m0_cyc = 1'b1;
    nxt(); #1;
    vectors++;
    if ({o_grant, o_busy, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_s_cyc, o_s_stb, o_s_we} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, want 0", {o_grant, o_busy, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_s_cyc, o_s_stb, o_s_we});
    end
    vectors++;
    if ({o_s_addr, o_s_data, o_s_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h, want 0", {o_s_addr, o_s_data, o_s_sel});
    end
    vectors++;
    if ({o_m0_stall, o_m1_stall} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_stall: got %b, want 10", {o_m0_stall, o_m1_stall});
    end
    nxt();
    i_m0_cyc = 1'b0;
    i_rst    = 1'b0;
  endtask

  task automatic test_single_read();
    req_t e;
    rsp_t r;
    nxt();
    m0(1, 1, 0, 10'h004, 32'h0, 4'hF);
    push_req(0, 0, 10'h004, 32'h0, 4'hF);
    #1;
    vectors++;
    if ({o_s_stb, o_grant} !== 3'b000) begin
      miscompares++;
      $display("FAIL rd_latency: got %b, want 000", {o_s_stb, o_grant});
    end
    nxt(); #1;
    e = req_q0.pop_front();
    vectors++;
    if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} !== {2'b11, e.we, e.addr, e.data, e.sel}) begin
      miscompares++;
      $display("FAIL rd_slave: got addr %h we %b, want addr %h we %b", o_s_addr, o_s_we, e.addr, e.we);
    end
    vectors++;
    if ({o_grant, o_m1_ack, o_m1_err, o_m1_stall, o_m0_ack} !== 6'b010000) begin
      miscompares++;
      $display("FAIL rd_quiet: got %b, want 010000", {o_grant, o_m1_ack, o_m1_err, o_m1_stall, o_m0_ack});
    end
    nxt();
    slv(1, 0, 32'h00C00193);
    push_rsp(0, 32'h00C00193);
    #1;
    r = rsp_q.pop_front();
    vectors++;
    if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data)} !== {r.m, ~r.m, r.data}) begin
      miscompares++;
      $display("FAIL rd_ack: got acks %b%b data %h, want data %h", o_m1_ack, o_m0_ack, o_m0_data, r.data);
    end
    nxt();
    idle_all();
    #1;
    vectors++;
    if ({o_s_cyc, o_s_stb} !== 2'b00) begin
      miscompares++;
      $display("FAIL rd_release: got %b, want 00", {o_s_cyc, o_s_stb});
    end
    nxt(); #1;
    vectors++;
    if ({o_busy, o_grant} !== 3'b000) begin
      miscompares++;
      $display("FAIL rd_idle: got %b, want 000", {o_busy, o_grant});
    end
  endtask

  task automatic test_tie();
    req_t e;
    rsp_t r;
    nxt();
    m0(1, 1, 0, 10'h010, 32'h0, 4'hF);
    m1(1, 1, 0, 10'h020, 32'h0, 4'hF);
    push_req(0, 0, 10'h010, 32'h0, 4'hF);
    push_req(1, 0, 10'h020, 32'h0, 4'hF);
    #1;
    nxt(); #1;
    vectors++;
    if ({o_grant, o_m1_stall} !== 3'b011) begin
      miscompares++;
      $display("FAIL tie_first: got %b, want 011", {o_grant, o_m1_stall});
    end
    e = req_q0.pop_front();
    vectors++;
    if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} !== {2'b11, e.we, e.addr, e.data, e.sel}) begin
      miscompares++;
      $display("FAIL tie_m0_req: got addr %h, want %h", o_s_addr, e.addr);
    end
    nxt();
    slv(1, 0, 32'h11111111);
    push_rsp(0, 32'h11111111);
    #1;
    r = rsp_q.pop_front();
    vectors++;
    if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data)} !== {r.m, ~r.m, r.data}) begin
      miscompares++;
      $display("FAIL tie_m0_ack: got acks %b%b, want %b%b", o_m1_ack, o_m0_ack, r.m, ~r.m);
    end
    nxt();
    m0(0, 0, 0, '0, '0, '0);
    slv(0, 0, '0);
    #1;
    nxt(); #1;
    vectors++;
    if ({o_grant, o_s_stb, o_busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL tie_gap: got %b, want 0000", {o_grant, o_s_stb, o_busy});
    end
    nxt(); #1;
    vectors++;
    if (o_grant !== 2'b10) begin
      miscompares++;
      $display("FAIL tie_second: got %b, want 10", o_grant);
    end
    e = req_q1.pop_front();
    vectors++;
    if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} !== {2'b11, e.we, e.addr, e.data, e.sel}) begin
      miscompares++;
      $display("FAIL tie_m1_req: got addr %h, want %h", o_s_addr, e.addr);
    end
    nxt();
    slv(1, 0, 32'h22222222);
    push_rsp(1, 32'h22222222);
    #1;
    r = rsp_q.pop_front();
    vectors++;
    if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data)} !== {r.m, ~r.m, r.data}) begin
      miscompares++;
      $display("FAIL tie_m1_ack: got acks %b%b data %h, want data %h", o_m1_ack, o_m0_ack, o_m1_data, r.data);
    end
    nxt();
    idle_all();
    #1;
    nxt();
    m0(1, 1, 0, 10'h014, 32'h0, 4'hF);
    m1(1, 1, 0, 10'h024, 32'h0, 4'hF);
    push_req(0, 0, 10'h014, 32'h0, 4'hF);
    #1;
    nxt(); #1;
    vectors++;
    if (o_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_alternate: got %b, want 01", o_grant);
    end
    e = req_q0.pop_front();
    vectors++;
    if (o_s_addr !== e.addr) begin
      miscompares++;
      $display("FAIL tie_alt_req: got addr %h, want %h", o_s_addr, e.addr);
    end
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_write();
    req_t e;
    rsp_t r;
    nxt();
    m1(1, 1, 1, 10'h034, 32'hA5A55A5A, 4'b0011);
    push_req(1, 1, 10'h034, 32'hA5A55A5A, 4'b0011);
    #1;
    nxt();
    m0(1, 1, 0, 10'h3FF, 32'h0, 4'hF);
    push_req(0, 0, 10'h3FF, 32'h0, 4'hF);
    #1;
    e = req_q1.pop_front();
    vectors++;
    if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} !== {2'b11, e.we, e.addr, e.data, e.sel}) begin
      miscompares++;
      $display("FAIL wr_slave: got we %b addr %h data %h sel %b, want we %b addr %h data %h sel %b",
               o_s_we, o_s_addr, o_s_data, o_s_sel, e.we, e.addr, e.data, e.sel);
    end
    vectors++;
    if ({o_grant, o_m0_stall, o_m0_ack} !== 4'b1010) begin
      miscompares++;
      $display("FAIL wr_m0_stall: got %b, want 1010", {o_grant, o_m0_stall, o_m0_ack});
    end
    nxt();
    slv(1, 0, 32'hDEADBEEF);
    push_rsp(1, 32'hDEADBEEF);
    #1;
    r = rsp_q.pop_front();
    vectors++;
    if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data), o_m0_stall} !== {r.m, ~r.m, r.data, 1'b1}) begin
      miscompares++;
      $display("FAIL wr_ack: got acks %b%b m0_stall %b, want 10 stall 1", o_m1_ack, o_m0_ack, o_m0_stall);
    end
    nxt();
    m1(0, 0, 0, '0, '0, '0);
    slv(0, 0, '0);
    #1;
    nxt(); #1;
    nxt(); #1;
    e = req_q0.pop_front();
    vectors++;
    if ({o_grant, o_s_stb, o_s_addr} !== {2'b01, 1'b1, e.addr}) begin
      miscompares++;
      $display("FAIL wr_next: got grant %b addr %h, want 01 addr %h", o_grant, o_s_addr, e.addr);
    end
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_bus_hold();
    req_t e;
    rsp_t r;
    nxt();
    m1(1, 1, 0, 10'h060, 32'h0, 4'hF);
    push_req(1, 0, 10'h060, 32'h0, 4'hF);
    #1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      slv(0, 0, '0);
      if (i == 0) begin
        m0(1, 1, 0, 10'h070, 32'h0, 4'hF);
        push_req(0, 0, 10'h070, 32'h0, 4'hF);
      end else begin
        i_m1_addr = AW'(10'h060 + 4 * i);
        push_req(1, 0, AW'(10'h060 + 4 * i), 32'h0, 4'hF);
      end
      #1;
      e = req_q1.pop_front();
      vectors++;
      if ({o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel} !== {2'b11, e.we, e.addr, e.data, e.sel}) begin
        miscompares++;
        $display("FAIL hold_req%0d: got addr %h, want %h", i, o_s_addr, e.addr);
      end
      vectors++;
      if ({o_m0_stall, o_m0_ack, o_grant} !== 4'b1010) begin
        miscompares++;
        $display("FAIL hold_stall%0d: got %b, want 1010", i, {o_m0_stall, o_m0_ack, o_grant});
      end
      nxt();
      slv(1, 0, 32'hB0000000 + i);
      push_rsp(1, 32'hB0000000 + i);
      #1;
      r = rsp_q.pop_front();
      vectors++;
      if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data), o_m0_stall} !== {r.m, ~r.m, r.data, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_ack%0d: got acks %b%b data %h stall %b, want data %h", i, o_m1_ack, o_m0_ack, o_m1_data, o_m0_stall, r.data);
      end
    end
    nxt();
    m1(0, 0, 0, '0, '0, '0);
    slv(0, 0, '0);
    #1;
    vectors++;
    if ({o_m0_stall, o_grant} !== 3'b110) begin
      miscompares++;
      $display("FAIL hold_release: got %b, want 110", {o_m0_stall, o_grant});
    end
    nxt(); #1;
    vectors++;
    if ({o_m0_stall, o_grant, o_s_stb} !== 4'b1000) begin
      miscompares++;
      $display("FAIL hold_gap: got %b, want 1000", {o_m0_stall, o_grant, o_s_stb});
    end
    nxt(); #1;
    e = req_q0.pop_front();
    vectors++;
    if ({o_grant, o_s_stb, o_s_addr} !== {2'b01, 1'b1, e.addr}) begin
      miscompares++;
      $display("FAIL hold_m0_grant: got grant %b addr %h, want 01 addr %h", o_grant, o_s_addr, e.addr);
    end
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_watchdog();
    req_t e;
    rsp_t r;
    nxt();
    m0(1, 1, 0, 10'h100, 32'h0, 4'hF);
    #1;
    for (int i = 0; i <= TO; i++) begin
      nxt(); #1;
      vectors++;
      if ({o_s_stb, o_m0_err, o_busy} !== 3'b101) begin
        miscompares++;
        $display("FAIL wd_wait%0d: got %b, want 101", i, {o_s_stb, o_m0_err, o_busy});
      end
    end
    nxt(); #1;
    vectors++;
    if ({o_m0_err, o_m1_err, o_s_cyc, o_s_stb, o_m0_stall, o_m0_ack} !== 6'b100010) begin
      miscompares++;
      $display("FAIL wd_err: got %b, want 100010", {o_m0_err, o_m1_err, o_s_cyc, o_s_stb, o_m0_stall, o_m0_ack});
    end
    nxt();
    slv(1, 0, 32'h0BADF00D);
    #1;
    vectors++;
    if ({o_m0_err, o_s_cyc, o_m0_ack, o_busy} !== 4'b0001) begin
      miscompares++;
      $display("FAIL wd_err_hold: got %b, want 0001", {o_m0_err, o_s_cyc, o_m0_ack, o_busy});
    end
    nxt();
    idle_all();
    #1;
    nxt();
    m1(1, 1, 0, 10'h200, 32'h0, 4'hF);
    push_req(1, 0, 10'h200, 32'h0, 4'hF);
    #1;
    vectors++;
    if ({o_busy, o_grant} !== 3'b000) begin
      miscompares++;
      $display("FAIL wd_idle: got %b, want 000", {o_busy, o_grant});
    end
    nxt(); #1;
    e = req_q1.pop_front();
    vectors++;
    if ({o_grant, o_s_cyc, o_s_stb, o_s_addr} !== {2'b10, 2'b11, e.addr}) begin
      miscompares++;
      $display("FAIL wd_m1_req: got grant %b addr %h, want 10 addr %h", o_grant, o_s_addr, e.addr);
    end
    nxt();
    slv(1, 0, 32'hCAFEF00D);
    push_rsp(1, 32'hCAFEF00D);
    #1;
    r = rsp_q.pop_front();
    vectors++;
    if ({o_m1_ack, o_m0_ack, (r.m ? o_m1_data : o_m0_data)} !== {r.m, ~r.m, r.data}) begin
      miscompares++;
      $display("FAIL wd_m1_ack: got acks %b%b data %h, want data %h", o_m1_ack, o_m0_ack, o_m1_data, r.data);
    end
    nxt();
    idle_all();
    nxt();
  endtask

  task automatic test_async_reset();
    nxt();
    m0(1, 1, 0, 10'h040, 32'h0, 4'hF);
    #1;
    nxt();
    m0(0, 0, 0, '0, '0, '0);
    #1;
    nxt();
    m0(1, 1, 0, 10'h044, 32'h0, 4'hF);
    #1;
    nxt();
    slv(1, 0, 32'h12345678);
    m1(1, 1, 0, 10'h050, 32'h0, 4'hF);
    #1;
    vectors++;
    if ({o_grant, o_m0_ack} !== 3'b011) begin
      miscompares++;
      $display("FAIL ar_busy: got %b, want 011", {o_grant, o_m0_ack});
    end
    #2;
    i_rst = 1'b1;
    #1;
    vectors++;
    if ({o_grant, o_busy, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_s_cyc, o_s_stb, o_s_we,
         o_s_addr, o_s_data, o_s_sel} !== '0) begin
      miscompares++;
      $display("FAIL ar_outputs: grant %b busy %b ack %b%b s_cyc %b s_stb %b, want all 0",
               o_grant, o_busy, o_m1_ack, o_m0_ack, o_s_cyc, o_s_stb);
    end
    vectors++;
    if ({o_m0_stall, o_m1_stall} !== 2'b11) begin
      miscompares++;
      $display("FAIL ar_stall: got %b, want 11", {o_m0_stall, o_m1_stall});
    end
    nxt();
    i_rst = 1'b0;
    slv(0, 0, '0);
    #1;
    nxt(); #1;
    vectors++;
    if (o_grant !== 2'b01) begin
      miscompares++;
      $display("FAIL ar_tie: got %b, want 01", o_grant);
    end
    nxt();
    idle_all();
    nxt();
  endtask

  initial begin
    test_reset();
    test_single_read();
    apply_reset();
    test_tie();
    test_write();
    test_bus_hold();
    test_watchdog();
    test_async_reset();
    vectors++;
    if (req_q0.size() + req_q1.size() + rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", req_q0.size() + req_q1.size() + rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
